jt10_mix_seq: RTL and testbench

- Downstream output mixer for the YM2610 path. Takes the per-sample FM left/right sums from the FM accumulator and the ADPCM-A and ADPCM-B stereo outputs.
- Applies a per-source gain, sums, saturates to 16 bits and presents one stereo sample per FM sample period with a strobe.
- Uses a single time-shared multiplier, sequenced by a small FSM.

---
 rtl/jt10_mix_seq.sv | 207 ++++++++++++++++++++
 tb/tb_jt10_mix_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jt10_mix_seq.sv
`default_nettype none
// ============================================================================
// Module   : jt10_mix_seq
// Purpose  : Output mixer for YM2610 audio. FM, ADPCM-A and ADPCM-B are
//            gain-scaled through one shared multiplier, summed per channel and
//            saturated to 16 bits. One stereo sample is produced per FM sample.
// Revision : 1.0  initial release
// ============================================================================
module jt10_mix_seq #(
    parameter int GW   = 8,
    parameter int FRAC = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_en,
    input  logic                 fm_sample,
    input  logic [15:0]          fm_left,
    input  logic [15:0]          fm_right,
    input  logic [15:0]          adpcmA_l,
    input  logic [15:0]          adpcmA_r,
    input  logic [15:0]          adpcmB_l,
    input  logic [15:0]          adpcmB_r,
    input  logic [GW-1:0]        gain_fm,
    input  logic [GW-1:0]        gain_a,
    input  logic [GW-1:0]        gain_b,
    output logic [15:0]          snd_left,
    output logic [15:0]          snd_right,
    output logic                 sample_out,
    output logic                 busy,
    output logic                 overrun
);

    // Product is signed 16 x (GW+1) bits; accumulator keeps two guard bits
    // above the product so three full-scale terms cannot wrap.
    localparam int c_PW = 17 + GW;
    localparam int c_AW = (GW + 19 > 26) ? GW + 19 : 26;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MAC  = 2'd1;
    localparam logic [1:0] c_SAT  = 2'd2;

    logic [1:0]             r_state;
    logic [2:0]             r_cnt;

    logic [15:0]            r_fl;
    logic [15:0]            r_fr;
    logic [15:0]            r_al;
    logic [15:0]            r_ar;
    logic [15:0]            r_bl;
    logic [15:0]            r_br;
    logic [GW-1:0]          r_gfm;
    logic [GW-1:0]          r_ga;
    logic [GW-1:0]          r_gb;

    logic signed [c_AW-1:0] r_acc_l;
    logic signed [c_AW-1:0] r_acc_r;

    logic [15:0]            r_snd_l;
    logic [15:0]            r_snd_r;
    logic                   r_sample;
    logic                   r_overrun;

    logic [15:0]            w_op;
    logic [GW-1:0]          w_gain;
    logic [c_PW-1:0]        w_op_x;
    logic [c_PW-1:0]        w_gain_x;
    logic signed [c_PW-1:0] w_prod;
    logic signed [c_AW-1:0] w_prod_x;
    logic signed [c_AW-1:0] w_sh_l;
    logic signed [c_AW-1:0] w_sh_r;
    logic [15:0]            w_sat_l;
    logic [15:0]            w_sat_r;

    // Clamp to 16 bits: in range only when every bit above bit 15 matches
    // the sign bit.
    function automatic logic [15:0] sat16(input logic [c_AW-1:0] v);
        logic [c_AW-16:0] upper;
        upper = v[c_AW-1:15];
        if ((upper == '0) || (upper == '1)) begin
            sat16 = v[15:0];
        end else if (v[c_AW-1]) begin
            sat16 = 16'h8000;
        end else begin
            sat16 = 16'h7fff;
        end
    endfunction

    always_comb begin
        w_op   = 16'd0;
        w_gain = '0;
        case (r_cnt)
            3'd0:    begin w_op = r_fl; w_gain = r_gfm; end
            3'd1:    begin w_op = r_fr; w_gain = r_gfm; end
            3'd2:    begin w_op = r_al; w_gain = r_ga;  end
            3'd3:    begin w_op = r_ar; w_gain = r_ga;  end
            3'd4:    begin w_op = r_bl; w_gain = r_gb;  end
            3'd5:    begin w_op = r_br; w_gain = r_gb;  end
            default: begin w_op = 16'd0; w_gain = '0;   end
        endcase
    end

    // Gain is unsigned, so it is zero-extended before the signed multiply.
    assign w_op_x   = {{(c_PW-16){w_op[15]}}, w_op};
    assign w_gain_x = {{(c_PW-GW){1'b0}}, w_gain};
    assign w_prod   = $signed(w_op_x) * $signed(w_gain_x);
    assign w_prod_x = {{(c_AW-c_PW){w_prod[c_PW-1]}}, w_prod};

    assign w_sh_l  = r_acc_l >>> FRAC;
    assign w_sh_r  = r_acc_r >>> FRAC;
    assign w_sat_l = sat16(w_sh_l);
    assign w_sat_r = sat16(w_sh_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_cnt     <= 3'd0;
            r_sample  <= 1'b0;
            r_overrun <= 1'b0;
        end else if (clk_en) begin
            r_sample  <= 1'b0;
            r_overrun <= fm_sample && (r_state != c_IDLE);
            case (r_state)
                c_IDLE: begin
                    if (fm_sample) begin
                        r_cnt   <= 3'd0;
                        r_state <= c_MAC;
                    end
                end
                c_MAC: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd5) begin
                        r_state <= c_SAT;
                    end
                end
                c_SAT: begin
                    r_sample <= 1'b1;
                    r_state  <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Snapshot is taken only on an accepted strobe; dropped strobes leave it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fl  <= 16'd0;
            r_fr  <= 16'd0;
            r_al  <= 16'd0;
            r_ar  <= 16'd0;
            r_bl  <= 16'd0;
            r_br  <= 16'd0;
            r_gfm <= '0;
            r_ga  <= '0;
            r_gb  <= '0;
        end else if (clk_en && (r_state == c_IDLE) && fm_sample) begin
            r_fl  <= fm_left;
            r_fr  <= fm_right;
            r_al  <= adpcmA_l;
            r_ar  <= adpcmA_r;
            r_bl  <= adpcmB_l;
            r_br  <= adpcmB_r;
            r_gfm <= gain_fm;
            r_ga  <= gain_a;
            r_gb  <= gain_b;
        end
    end

    // Even counter slots feed the left accumulator, odd slots the right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_l <= '0;
            r_acc_r <= '0;
        end else if (clk_en) begin
            if ((r_state == c_IDLE) && fm_sample) begin
                r_acc_l <= '0;
                r_acc_r <= '0;
            end else if (r_state == c_MAC) begin
                if (r_cnt[0]) begin
                    r_acc_r <= r_acc_r + w_prod_x;
                end else begin
                    r_acc_l <= r_acc_l + w_prod_x;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snd_l <= 16'd0;
            r_snd_r <= 16'd0;
        end else if (clk_en && (r_state == c_SAT)) begin
            r_snd_l <= w_sat_l;
            r_snd_r <= w_sat_r;
        end
    end

    assign snd_left   = r_snd_l;
    assign snd_right  = r_snd_r;
    assign sample_out = r_sample;
    assign overrun    = r_overrun;
    assign busy       = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_jt10_mix_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_jt10_mix_seq
// Purpose  : Self-checking bench for jt10_mix_seq (vector table, corner
//            sequences and randomized mixes against an arithmetic model).
// Revision : 1.0  initial release
// ============================================================================
module tb_jt10_mix_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b0;
    logic        fm_sample = 1'b0;
    logic [15:0] fm_left, fm_right, adpcmA_l, adpcmA_r, adpcmB_l, adpcmB_r;
    logic [7:0]  gain_fm, gain_a, gain_b;
    logic [15:0] snd_left, snd_right;
    logic        sample_out, busy, overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int div     = 1;

    typedef struct {
        logic [15:0] fl, fr, al, ar, bl, br;
        logic [7:0]  gf, ga, gb;
        int          el, er;
    } vec_t;

    jt10_mix_seq #(.GW(8), .FRAC(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .fm_sample  (fm_sample),
        .fm_left    (fm_left),
        .fm_right   (fm_right),
        .adpcmA_l   (adpcmA_l),
        .adpcmA_r   (adpcmA_r),
        .adpcmB_l   (adpcmB_l),
        .adpcmB_r   (adpcmB_r),
        .gain_fm    (gain_fm),
        .gain_a     (gain_a),
        .gain_b     (gain_b),
        .snd_left   (snd_left),
        .snd_right  (snd_right),
        .sample_out (sample_out),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One channel of the mix: weighted sum, floor-divide by 16, clamp.
    function automatic int model_ch(int a, int b, int c, int ga, int gb, int gc);
        longint s;
        s = longint'(a) * ga + longint'(b) * gb + longint'(c) * gc;
        s = s >>> 4;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    function automatic vec_t mk(int fl, int fr, int al, int ar, int bl, int br,
                                int gf, int ga, int gb, int el, int er);
        vec_t v;
        v.fl = 16'(fl); v.fr = 16'(fr); v.al = 16'(al);
        v.ar = 16'(ar); v.bl = 16'(bl); v.br = 16'(br);
        v.gf = 8'(gf);  v.ga = 8'(ga);  v.gb = 8'(gb);
        v.el = el;      v.er = er;
        return v;
    endfunction

    task automatic chk(string nm, longint act, longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clk_en edge; with div>1 the idle cycles before it must not move state.
    task automatic en_cycle();
        logic [15:0] sl;
        logic        b, so;
        if (div > 1) begin
            clk_en = 1'b0;
            sl = snd_left; b = busy; so = sample_out;
            repeat (div - 1) step();
            chk("freeze_busy", busy, b);
            chk("freeze_sample_out", sample_out, so);
            chk("freeze_snd_left", snd_left, sl);
        end
        clk_en = 1'b1;
        step();
        clk_en = 1'b0;
    endtask

    task automatic apply(vec_t v);
        fm_left = v.fl;  fm_right = v.fr;
        adpcmA_l = v.al; adpcmA_r = v.ar;
        adpcmB_l = v.bl; adpcmB_r = v.br;
        gain_fm = v.gf;  gain_a = v.ga; gain_b = v.gb;
    endtask

    task automatic scramble();
        fm_left  = 16'($urandom); fm_right = 16'($urandom);
        adpcmA_l = 16'($urandom); adpcmA_r = 16'($urandom);
        adpcmB_l = 16'($urandom); adpcmB_r = 16'($urandom);
        gain_fm  = 8'($urandom);  gain_a = 8'($urandom); gain_b = 8'($urandom);
    endtask

    // Strobe at edge 0, optional dropped strobe at dup_edge, check through edge 7.
    task automatic run_mix(vec_t v, int dup_edge);
        apply(v);
        fm_sample = 1'b1;
        en_cycle();
        fm_sample = 1'b0;
        scramble();
        chk("edge0_busy", busy, 1);
        chk("edge0_sample_out", sample_out, 0);
        for (int e = 1; e <= 7; e++) begin
            fm_sample = (e == dup_edge);
            en_cycle();
            fm_sample = 1'b0;
            chk("overrun", overrun, (e == dup_edge) ? 1 : 0);
            if (e < 7) begin
                chk("mid_busy", busy, 1);
                chk("mid_sample_out", sample_out, 0);
            end else begin
                chk("edge7_busy", busy, 0);
                chk("edge7_sample_out", sample_out, 1);
                chk("snd_left", $signed(snd_left), v.el);
                chk("snd_right", $signed(snd_right), v.er);
            end
        end
    endtask

    task automatic after_mix(vec_t v);
        fm_sample = 1'b0;
        en_cycle();
        chk("edge8_sample_out", sample_out, 0);
        chk("edge8_overrun", overrun, 0);
        chk("edge8_busy", busy, 0);
        chk("hold_snd_left", $signed(snd_left), v.el);
        chk("hold_snd_right", $signed(snd_right), v.er);
    endtask

    initial begin
        vec_t tbl[7];
        vec_t v;
        int   pulses;

        tbl[0] = mk(1000, -1000, 5000, -7000, 123, -4, 'h10, 'h00, 'h00, 1000, -1000);
        tbl[1] = mk(1000, 0, 2000, 0, -500, 0, 'h10, 'h20, 'h08, 4750, 0);
        tbl[2] = mk(30000, -30000, 30000, -30000, 0, 0, 'h20, 'h10, 'h00, 32767, -32768);
        tbl[3] = mk(-1, 1, 0, 0, 0, 0, 'h08, 'h00, 'h00, -1, 0);
        tbl[4] = mk(-32768, -32768, -32768, -32768, -32768, -32768, 'hff, 'hff, 'hff, -32768, -32768);
        tbl[5] = mk(-20000, 7, 3, 0, 0, 9, 'h10, 'h05, 'h03, -20000, 8);
        tbl[6] = mk(32767, 32767, 32767, 32767, 32767, 32767, 'hff, 'hff, 'hff, 32767, 32767);

        scramble();
        repeat (3) step();
        chk("reset_snd_left", snd_left, 0);
        chk("reset_snd_right", snd_right, 0);
        chk("reset_busy", busy, 0);
        chk("reset_sample_out", sample_out, 0);
        chk("reset_overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int d = 1; d <= 3; d += 2) begin
            div = d;
            for (int i = 0; i < 7; i++) begin
                run_mix(tbl[i], 0);
                after_mix(tbl[i]);
            end
            // Dropped strobe at edge 3, then a strobe at edge 8 that is accepted.
            run_mix(tbl[1], 3);
            run_mix(tbl[2], 0);
            after_mix(tbl[2]);
            // Strobe while in the saturate state is also dropped.
            run_mix(tbl[5], 7);
            after_mix(tbl[5]);
        end

        for (int k = 0; k < 40; k++) begin
            v = mk(int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                   int'($urandom), int'($urandom), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0, 0);
            if ($urandom_range(0, 3) == 0) v.ga = 8'd0;
            v.el = model_ch($signed(v.fl), $signed(v.al), $signed(v.bl), v.gf, v.ga, v.gb);
            v.er = model_ch($signed(v.fr), $signed(v.ar), $signed(v.br), v.gf, v.ga, v.gb);
            div = $urandom_range(1, 3);
            run_mix(v, $urandom_range(0, 9));
            if ($urandom_range(0, 1) == 1) after_mix(v);
        end

        // Reset in the middle of a mix.
        div = 1;
        run_mix(tbl[0], 0);
        after_mix(tbl[0]);
        apply(tbl[1]);
        fm_sample = 1'b1;
        en_cycle();
        fm_sample = 1'b0;
        repeat (3) en_cycle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_snd_left", snd_left, 0);
        chk("midreset_snd_right", snd_right, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_sample_out", sample_out, 0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            en_cycle();
            if (sample_out) pulses++;
        end
        chk("midreset_no_sample", pulses, 0);
        chk("midreset_idle", busy, 0);
        v = mk(123, 0, 0, 0, 0, 0, 'h10, 'h00, 'h00, 123, 0);
        run_mix(v, 0);
        after_mix(v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
